rom_arbiter: RTL

//   Shares the single combinational byte-addressed instruction ROM between two requesters: the

---
 rtl/rom_arbiter_pkg.sv | 17 +
 rtl/rom_arbiter.sv | 94 +++++++++
 2 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared constants and grant encoding for the instruction-ROM arbiter.
// The default ROM size is kept here so the ROM model and the arbiter agree.
package rom_arbiter_pkg;

    localparam int ROM_ADDR_W    = 32;
    localparam int ROM_DATA_W    = 32;
    localparam int ROM_BYTES_DEF = 4096;
    localparam int MEM_MAX_DEF   = 4;
    localparam int CONSEC_W      = 4;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_MEM  = 2'd2
    } gnt_e;

endpackage

// File: rtl/rom_arbiter.sv
// Shares the combinational instruction ROM between the IF and MEM requesters, one grant per cycle.
// Latency: grant in cycle N, registered response in N+1 (single-cycle pulse).
// Backpressure: requests wait on ready; MEM preferred, IF forced through after MEM_MAX_CONSEC losses.
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int ADDR_W         = ROM_ADDR_W,
    parameter int DATA_W         = ROM_DATA_W,
    parameter int ROM_BYTES      = ROM_BYTES_DEF,
    parameter int MEM_MAX_CONSEC = MEM_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    input  logic [ADDR_W-1:0] if_req_addr,
    output logic              if_req_ready,
    input  logic              if_flush,
    output logic              if_rsp_valid,
    output logic [DATA_W-1:0] if_rsp_data,
    output logic              if_rsp_err,
    input  logic              mem_req_valid,
    input  logic [ADDR_W-1:0] mem_req_addr,
    output logic              mem_req_ready,
    output logic              mem_rsp_valid,
    output logic [DATA_W-1:0] mem_rsp_data,
    output logic              mem_rsp_err,
    output logic              rom_ce,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_inst
);

    localparam logic [ADDR_W-1:0]   ROM_LAST   = ADDR_W'(ROM_BYTES - 4);
    localparam logic [CONSEC_W-1:0] CONSEC_MAX = CONSEC_W'(MEM_MAX_CONSEC);

    gnt_e              gnt;
    logic [ADDR_W-1:0] gnt_addr;
    logic              in_range;
    logic [CONSEC_W-1:0] consec;

    always_comb begin
        gnt           = GNT_NONE;
        gnt_addr      = '0;
        in_range      = 1'b0;
        if_req_ready  = 1'b0;
        mem_req_ready = 1'b0;
        rom_ce        = 1'b0;
        rom_addr      = '0;
        if (rst) begin
            // IF only overrides MEM once MEM has won MEM_MAX_CONSEC times while IF was waiting
            if (mem_req_valid && !(consec == CONSEC_MAX && if_req_valid)) begin
                gnt      = GNT_MEM;
                gnt_addr = mem_req_addr;
            end else if (if_req_valid) begin
                gnt      = GNT_IF;
                gnt_addr = if_req_addr;
            end
        end
        in_range      = (gnt_addr <= ROM_LAST);
        if_req_ready  = (gnt == GNT_IF);
        mem_req_ready = (gnt == GNT_MEM);
        rom_ce        = (gnt != GNT_NONE) && in_range;
        rom_addr      = gnt_addr;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rsp_valid  <= 1'b0;
            if_rsp_err    <= 1'b0;
            if_rsp_data   <= '0;
            mem_rsp_valid <= 1'b0;
            mem_rsp_err   <= 1'b0;
            mem_rsp_data  <= '0;
            consec        <= '0;
        end else begin
            // a flush in the grant cycle squashes the response but the grant is still consumed
            if_rsp_valid  <= (gnt == GNT_IF) && !if_flush;
            if_rsp_err    <= (gnt == GNT_IF) && !if_flush && !in_range;
            mem_rsp_valid <= (gnt == GNT_MEM);
            mem_rsp_err   <= (gnt == GNT_MEM) && !in_range;
            if (gnt == GNT_IF) begin
                if_rsp_data <= in_range ? rom_inst : '0;
            end
            if (gnt == GNT_MEM) begin
                mem_rsp_data <= in_range ? rom_inst : '0;
            end
            if (!if_req_valid || gnt == GNT_IF) begin
                consec <= '0;
            end else if (gnt == GNT_MEM && consec != CONSEC_MAX) begin
                consec <= consec + 1'b1;
            end
        end
    end

endmodule
